// File: rtl/multiplexador_display_if.sv
// Digit/load inputs and scanned display outputs of the five-digit multiplexed display driver.
// Producer side (BCD source plus display observer) uses master; the driver uses slave.
interface multiplexador_display_if;
    logic       carregar;
    logic [3:0] dezenaMilhar;
    logic [3:0] unidadeMilhar;
    logic [3:0] centena;
    logic [3:0] dezena;
    logic [3:0] unidade;
    logic       apagarZeros;
    logic [6:0] segmentos;
    logic [4:0] anodos;
    logic       quadro;

    modport master (
        output carregar, dezenaMilhar, unidadeMilhar, centena, dezena, unidade, apagarZeros,
        input  segmentos, anodos, quadro
    );

    modport slave (
        input  carregar, dezenaMilhar, unidadeMilhar, centena, dezena, unidade, apagarZeros,
        output segmentos, anodos, quadro
    );
endinterface

// File: rtl/multiplexador_display.sv
// Five-digit common-anode seven-segment scanner: buffered load, tear-free commit at frame
// boundaries, optional leading-zero blanking and a dash for non-BCD digits.
module multiplexador_display #(
    parameter int DIVISOR = 50000
) (
    input logic                    clock,
    input logic                    reset,
    multiplexador_display_if.slave bus
);
    localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

    logic [CW-1:0]   cont_q, cont_d;
    logic [2:0]      idx_q, idx_d;
    logic [4:0][3:0] buffer_q, buffer_d;
    logic [4:0][3:0] vis_q, vis_d;
    logic            pendente_q, pendente_d;
    logic [6:0]      segmentos_q, segmentos_d;
    logic [4:0]      anodos_q, anodos_d;
    logic            quadro_q, quadro_d;

    logic [4:0][3:0] entrada;
    logic            tick;
    logic            fronteira;
    logic            apagar;
    logic [3:0]      digito;

    assign entrada   = {bus.dezenaMilhar, bus.unidadeMilhar, bus.centena, bus.dezena, bus.unidade};
    assign tick      = (cont_q == CW'(DIVISOR - 1));
    assign fronteira = tick && (idx_q == 3'd4);

    function automatic logic [6:0] decodifica(input logic [3:0] d);
        case (d)
            4'd0:    decodifica = 7'h01;
            4'd1:    decodifica = 7'h4F;
            4'd2:    decodifica = 7'h12;
            4'd3:    decodifica = 7'h06;
            4'd4:    decodifica = 7'h4C;
            4'd5:    decodifica = 7'h24;
            4'd6:    decodifica = 7'h20;
            4'd7:    decodifica = 7'h0F;
            4'd8:    decodifica = 7'h00;
            4'd9:    decodifica = 7'h04;
            default: decodifica = 7'h7E;
        endcase
    endfunction

    // Prescaler, scan index and the load/commit path.
    always_comb begin
        cont_d     = tick ? '0 : cont_q + CW'(1);
        idx_d      = idx_q;
        buffer_d   = buffer_q;
        vis_d      = vis_q;
        pendente_d = pendente_q;
        if (tick) begin
            idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end
        // A load landing on the boundary bypasses the buffer so it is never a frame late.
        if (fronteira) begin
            if (bus.carregar) begin
                vis_d    = entrada;
                buffer_d = entrada;
            end else if (pendente_q) begin
                vis_d = buffer_q;
            end
            pendente_d = 1'b0;
        end else if (bus.carregar) begin
            buffer_d   = entrada;
            pendente_d = 1'b1;
        end
    end

    // Outputs follow the next-state index so they step on the same edge as idx.
    always_comb begin
        digito = 4'd0;
        for (int j = 0; j < 5; j++) begin
            if (idx_d == 3'(j)) digito = vis_d[j];
        end
        apagar = bus.apagarZeros && (idx_d != 3'd0);
        for (int j = 0; j < 5; j++) begin
            if ((3'(j) >= idx_d) && (vis_d[j] != 4'd0)) apagar = 1'b0;
        end
        segmentos_d = segmentos_q;
        anodos_d    = anodos_q;
        if (tick) begin
            segmentos_d = apagar ? 7'h7F : decodifica(digito);
            anodos_d    = ~(5'b00001 << idx_d);
        end
        quadro_d = fronteira;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cont_q      <= '0;
            idx_q       <= 3'd4;
            buffer_q    <= '0;
            vis_q       <= '0;
            pendente_q  <= 1'b0;
            segmentos_q <= 7'h7F;
            anodos_q    <= 5'h1F;
            quadro_q    <= 1'b0;
        end else begin
            cont_q      <= cont_d;
            idx_q       <= idx_d;
            buffer_q    <= buffer_d;
            vis_q       <= vis_d;
            pendente_q  <= pendente_d;
            segmentos_q <= segmentos_d;
            anodos_q    <= anodos_d;
            quadro_q    <= quadro_d;
        end
    end

    assign bus.segmentos = segmentos_q;
    assign bus.anodos    = anodos_q;
    assign bus.quadro    = quadro_q;
endmodule

// File: tb/tb_multiplexador_display.sv
// Self-checking bench for multiplexador_display: directed scenarios plus random loads,
// compared every cycle against a cycle-count based reference model.
module tb_multiplexador_display;
    localparam int D = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    multiplexador_display_if bus ();
    multiplexador_display #(.DIVISOR(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: edge count since reset drives everything.
    logic [6:0] tabela [16];
    int  k;
    int  latest [5];
    int  shown  [5];
    bit  dirty;
    logic [6:0] m_seg;
    logic [4:0] m_an;
    bit  m_quadro;
    bit  apg_cur;

    initial begin
        tabela = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                   7'h00, 7'h04, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E};
    end

    function automatic logic [19:0] pack(input int d4, input int d3, input int d2,
                                         input int d1, input int d0);
        pack = {d4[3:0], d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
    endfunction

    task automatic model_edge(input bit car, input logic [19:0] dig, input bit apg, input bit rst);
        int  pos;
        bit  tick, boundary, blank;
        if (rst) begin
            k = 0; dirty = 0;
            for (int i = 0; i < 5; i++) begin latest[i] = 0; shown[i] = 0; end
            m_seg = 7'h7F; m_an = 5'h1F; m_quadro = 0;
            return;
        end
        k++;
        tick     = (k % D) == 0;
        pos      = tick ? ((k / D) - 1) % 5 : 0;
        boundary = tick && (pos == 0);
        if (boundary) begin
            if (car) for (int i = 0; i < 5; i++) begin
                latest[i] = int'(dig[4*i +: 4]); shown[i] = latest[i];
            end
            else if (dirty) for (int i = 0; i < 5; i++) shown[i] = latest[i];
            dirty = 0;
        end else if (car) begin
            for (int i = 0; i < 5; i++) latest[i] = int'(dig[4*i +: 4]);
            dirty = 1;
        end
        m_quadro = boundary;
        if (tick) begin
            blank = apg && (pos >= 1);
            for (int j = pos; j < 5; j++) if (shown[j] != 0) blank = 0;
            m_seg = blank ? 7'h7F : tabela[shown[pos]];
            m_an  = ~(5'b00001 << pos);
        end
    endtask

    task automatic step(input bit car, input logic [19:0] dig, input bit apg, input bit rst);
        @(negedge clock);
        reset             = rst;
        bus.carregar      = car;
        bus.dezenaMilhar  = dig[19:16];
        bus.unidadeMilhar = dig[15:12];
        bus.centena       = dig[11:8];
        bus.dezena        = dig[7:4];
        bus.unidade       = dig[3:0];
        bus.apagarZeros   = apg;
        @(posedge clock);
        model_edge(car, dig, apg, rst);
        #1;
        check("segmentos", 32'(bus.segmentos), 32'(m_seg));
        check("anodos",    32'(bus.anodos),    32'(m_an));
        check("quadro",    32'(bus.quadro),    32'(m_quadro));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 20'h0, apg_cur, 1'b0);
    endtask

    task automatic run_to_boundary();
        for (int i = 0; i < 5 * D && ((k + 1) % (5 * D)) != D; i++) step(1'b0, 20'h0, apg_cur, 1'b0);
    endtask

    initial begin
        reset = 1'b1; bus.carregar = 1'b0; bus.apagarZeros = 1'b0;
        bus.dezenaMilhar = '0; bus.unidadeMilhar = '0; bus.centena = '0;
        bus.dezena = '0; bus.unidade = '0;
        apg_cur = 1'b0;

        // Reset state, then digits 1..5 loaded in cycle 1.
        step(1'b0, 20'h0, 1'b0, 1'b1);
        step(1'b0, 20'h0, 1'b0, 1'b1);
        check("reset_seg", 32'(bus.segmentos), 32'h7F);
        check("reset_an",  32'(bus.anodos),    32'h1F);
        step(1'b1, pack(1, 2, 3, 4, 5), 1'b0, 1'b0);
        idle(2);
        check("dark_before_tick", 32'(bus.anodos), 32'h1F);
        idle(1);
        check("first_frame_quadro", 32'(bus.quadro), 32'h1);
        check("first_frame_an",     32'(bus.anodos), 32'h1E);
        check("first_frame_seg",    32'(bus.segmentos), 32'h24);
        idle(D);
        check("pos1_seg", 32'(bus.segmentos), 32'h4C);
        idle(3 * D);
        check("pos4_seg", 32'(bus.segmentos), 32'h4F);

        // Mid-frame load of 9s, then two loads in one frame (last wins).
        run_to_boundary(); idle(D + 1);
        step(1'b1, pack(9, 9, 9, 9, 9), 1'b0, 1'b0);
        idle(10 * D);
        step(1'b1, pack(1, 1, 1, 1, 1), 1'b0, 1'b0);
        idle(3);
        step(1'b1, pack(2, 2, 2, 2, 2), 1'b0, 1'b0);
        idle(10 * D);

        // Load exactly on the boundary tick with blanking.
        apg_cur = 1'b1;
        run_to_boundary();
        step(1'b1, pack(0, 0, 0, 4, 2), 1'b1, 1'b0);
        check("bnd_load_seg", 32'(bus.segmentos), 32'h12);
        idle(5 * D);
        run_to_boundary();
        step(1'b1, pack(0, 0, 0, 0, 0), 1'b1, 1'b0);
        check("zero_pos0_seg", 32'(bus.segmentos), 32'h01);
        idle(D);
        check("zero_pos1_blank", 32'(bus.segmentos), 32'h7F);
        idle(5 * D);

        // Invalid digit stops blanking below it.
        step(1'b1, pack(0, 0, 12, 0, 7), 1'b1, 1'b0);
        idle(12 * D);

        // Reset mid-frame with data pending.
        step(1'b1, pack(3, 3, 3, 3, 3), 1'b1, 1'b0);
        step(1'b0, 20'h0, 1'b1, 1'b1);
        check("midreset_seg",    32'(bus.segmentos), 32'h7F);
        check("midreset_an",     32'(bus.anodos),    32'h1F);
        check("midreset_quadro", 32'(bus.quadro),    32'h0);
        idle(6 * D);

        // Random loads, digits biased toward zero, occasional blanking toggle and reset.
        for (int n = 0; n < 3000; n++) begin
            logic [19:0] dig;
            bit car, rst;
            for (int i = 0; i < 5; i++)
                dig[4*i +: 4] = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(0, 15));
            car = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) == 0) apg_cur = ~apg_cur;
            step(car, dig, apg_cur, rst);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multiplexador_display.md
# multiplexador_display

Time-multiplexed driver for a five-digit common-anode seven-segment display. It sits directly downstream of the binary-to-BCD converter and consumes its five BCD digits (dezenaMilhar..unidade). On a load strobe it captures the digits and holds them in a buffer. It commits the buffer to the visible digits only at a scan-frame boundary, so the display never tears. It scans one digit per prescaler period, with optional leading-zero blanking and an invalid-digit indication.

## Interface
- DIVISOR, 50000: clock cycles per digit slot; legal range ≥ 2; prescaler width is $clog2(DIVISOR).
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- carregar  in  1  load strobe; samples the five digit inputs in the same cycle.
- dezenaMilhar  in  4  BCD digit, position 4 (leftmost).
- unidadeMilhar  in  4  BCD digit, position 3.
- centena  in  4  BCD digit, position 2.
- dezena  in  4  BCD digit, position 1.
- unidade  in  4  BCD digit, position 0 (rightmost).
- apagarZeros  in  1  level; 1 enables leading-zero blanking.
- segmentos  out  7  active-low segments; bit6=a, bit5=b, …, bit0=g.
- anodos  out  5  active-low digit enables; bit i = position i; at most one bit low.
- quadro  out  1  one-cycle pulse marking the start of each scan frame.

## Operation
- State:
  - prescaler counter `cont` (0..DIVISOR-1);
  - digit index `idx` (0..4);
  - buffer registers `buf[4:0]` and `pendente`;
  - display registers `vis[4:0]`;
  - registered outputs.
- Tick: asserted when cont == DIVISOR-1. On a tick, cont→0; otherwise cont+1.
- Scan order: on a tick, idx advances 0→1→2→3→4→0. The transition 4→0 is a frame boundary.
- Load (carregar=1, no frame-boundary tick in the same cycle):
  - buf ← inputs; pendente ← 1.
  - A later carregar before the boundary overwrites buf (last wins).
- Commit (frame-boundary tick and pendente=1, carregar=0): vis ← buf; pendente ← 0.
- Simultaneous carregar and frame-boundary tick:
  - vis ← current inputs directly; buf ← inputs; pendente ← 0.
  - The older buffer contents are discarded.
- Decode of the digit vis[idx], active-low, abcdefg:
  - 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, 4=7'h4C;
  - 5=7'h24, 6=7'h20, 7=7'h0F, 8=7'h00, 9=7'h04;
  - values 10..15 → dash 7'h7E.
- Blanking: position i (i≥1) is blanked (segmentos=7'h7F) when apagarZeros=1 and vis[4..i] are all 4'd0.
  - Position 0 is never blanked.
  - Invalid digits are never treated as zero.
  - apagarZeros is sampled live, with no latching.
- anodos = ~(5'b1 << idx) whenever a digit is driven. A blanked position still has its anode driven low.

## Timing
- Reset values:
  - cont=0, idx=4, buf=0, vis=0, pendente=0;
  - segmentos=7'h7F, anodos=5'h1F, quadro=0.
- The first tick after reset occurs at the DIVISOR-th rising edge after reset deasserts. It is a frame boundary (idx 4→0).
- segmentos/anodos are registered and computed from next-state idx and vis:
  - they change on the same edge as idx;
  - they are constant for DIVISOR cycles per slot.
- quadro = 1 for exactly the one cycle following the boundary edge. Period is 5·DIVISOR cycles.
- Load-to-display latency:
  - data is visible from the next frame-boundary edge;
  - worst case 5·DIVISOR cycles, best case the same edge (simultaneous case).
- The anodos/segmentos values in the cycle between reset and the first tick stay at the reset values (display dark).
- Reset mid-frame or with pendente=1: everything returns to reset values; buffered data is lost.
- carregar needs no handshake and is accepted every cycle.

## Test plan
- Reset, DIVISOR=4, carregar with digits 1,2,3,4,5 (pos4..0) in cycle 1 -> at edge 4, quadro pulses, anodos=5'b11110, segmentos=7'h24 (digit 5). Every 4 cycles the output steps to pos1..pos4 with 7'h4C, 7'h06, 7'h12, 7'h4F.
- Mid-frame carregar 9,9,9,9,9 while showing 1..5 -> the remaining slots in the frame still show the old digits. The next frame shows 7'h04 on all positions.
- Two carregar pulses in one frame (values 11111 then 22222) -> the next frame shows only 2s. pendente clears after the commit.
- carregar of 0,0,0,4,2 exactly on the boundary tick -> committed on that edge. With apagarZeros=1, pos4..2 give 7'h7F, pos1=7'h4C, pos0=7'h12. With value 00000, pos0 shows 7'h01 and the others are blank.
- Digit value 4'hC at pos2, with pos4 and pos3 at 0 and apagarZeros=1 -> pos2=7'h7E, pos4 and pos3 blank, and pos1 is not blanked even if it is 0.
- reset asserted mid-frame with pendente=1 -> the next edge gives segmentos=7'h7F, anodos=5'h1F, quadro=0. After release with no load, the first frame shows 7'h01 on pos0 only when apagarZeros=1.
